// File: rtl/pe_param.sv
// pe_param: loads a filter once, then slides a 1-D ifmap window over F+1 output columns.
// Optional macro PE_RELU_EN adds i_config[13] (relu) and clamps negative opsums to 0.
module pe_param #(
  parameter int ELEM_W       = 8,
  parameter int LANES        = 4,
  parameter int PSUM_W       = 32,
  parameter int IFMAP_DEPTH  = 12,
  parameter int FILTER_DEPTH = 48,
  parameter int PSUM_DEPTH   = 4,
`ifdef PE_RELU_EN
  localparam int CFG_W = 14
`else
  localparam int CFG_W = 13
`endif
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      PE_en,
  input  logic [CFG_W-1:0]          i_config,
  input  logic [LANES*ELEM_W-1:0]   ifmap,
  input  logic [LANES*ELEM_W-1:0]   filter,
  input  logic [PSUM_W-1:0]         ipsum,
  input  logic                      ifmap_valid,
  input  logic                      filter_valid,
  input  logic                      ipsum_valid,
  input  logic                      opsum_ready,
  output logic                      ifmap_ready,
  output logic                      filter_ready,
  output logic                      ipsum_ready,
  output logic                      opsum_valid,
  output logic [PSUM_W-1:0]         opsum,
  output logic                      busy,
  output logic                      done,
  output logic                      cfg_err
);
  localparam int IAW = (IFMAP_DEPTH  > 1) ? $clog2(IFMAP_DEPTH)  : 1;
  localparam int FAW = (FILTER_DEPTH > 1) ? $clog2(FILTER_DEPTH) : 1;
  localparam int PAW = (PSUM_DEPTH   > 1) ? $clog2(PSUM_DEPTH)   : 1;

  typedef enum logic [2:0] {IDLE, RD_FLT, RD_IFM, RD_IPS, CONV, WR_OPS} state_e;
  state_e state_q, state_d;

  logic [CFG_W-1:0]  cfg_q, cfg_d;
  logic              cfg_err_q, cfg_err_d;
  logic [4:0]        col_q, col_d;
  logic [7:0]        cnt_q, cnt_d, j_q, j_d, k_q, k_d, l_q, l_d;
  logic [ELEM_W-1:0] flt_q  [FILTER_DEPTH], flt_d  [FILTER_DEPTH];
  logic [ELEM_W-1:0] ifm_q  [IFMAP_DEPTH],  ifm_d  [IFMAP_DEPTH];
  logic [PSUM_W-1:0] psum_q [PSUM_DEPTH],   psum_d [PSUM_DEPTH];

  logic              dw, mode, last_ops, legal;
  logic [7:0]        q_n, rs_n, p_n, qrs, fl, nps, tgt;
  logic [7:0]        iq, irs, ip, iqrs;
  logic [ELEM_W-1:0] flip;
  logic signed [2*ELEM_W-1:0] prod;
  logic [PSUM_W-1:0] ops;

  assign dw   = cfg_q[12];
  assign mode = cfg_q[9];
  assign q_n  = 8'(cfg_q[1:0]) + 8'd1;
  assign rs_n = 8'(cfg_q[11:10]) + 8'd1;
  assign p_n  = 8'(cfg_q[8:7]) + 8'd1;
  assign qrs  = q_n * rs_n;
  assign fl   = dw ? qrs : p_n * qrs;
  assign nps  = dw ? q_n : p_n;
  assign tgt  = dw ? l_q : k_q;
  assign flip = mode ? '0 : {1'b1, {(ELEM_W-1){1'b0}}};
  assign prod = $signed(flt_q[FAW'(cnt_q)]) * $signed(ifm_q[IAW'(j_q)]);

  // Legality is judged on the incoming config, before it is latched.
  assign iq   = 8'(i_config[1:0]) + 8'd1;
  assign irs  = 8'(i_config[11:10]) + 8'd1;
  assign ip   = 8'(i_config[8:7]) + 8'd1;
  assign iqrs = iq * irs;
  assign legal = (int'(iq) <= LANES) && (int'(iqrs) <= IFMAP_DEPTH)
              && (int'(i_config[12] ? iqrs : ip * iqrs) <= FILTER_DEPTH)
              && (int'(i_config[12] ? iq : ip) <= PSUM_DEPTH);

  assign filter_ready = (state_q == RD_FLT);
  assign ifmap_ready  = (state_q == RD_IFM);
  assign ipsum_ready  = (state_q == RD_IPS);
  assign opsum_valid  = (state_q == WR_OPS);
  assign busy         = (state_q != IDLE);
  assign cfg_err      = cfg_err_q;
  assign last_ops     = (cnt_q == nps - 8'd1);
  assign done         = opsum_valid && opsum_ready && last_ops && (col_q == cfg_q[6:2]);

  assign ops = psum_q[PAW'(cnt_q)];
`ifdef PE_RELU_EN
  assign opsum = (opsum_valid && !(cfg_q[13] && ops[PSUM_W-1])) ? ops : '0;
`else
  assign opsum = opsum_valid ? ops : '0;
`endif

  always_comb begin
    state_d   = state_q;
    cfg_d     = cfg_q;
    cfg_err_d = cfg_err_q;
    col_d     = col_q;
    cnt_d     = cnt_q;
    j_d       = j_q;
    k_d       = k_q;
    l_d       = l_q;
    flt_d     = flt_q;
    ifm_d     = ifm_q;
    psum_d    = psum_q;
    case (state_q)
      IDLE: if (PE_en) begin
        cfg_d     = i_config;
        cfg_err_d = !legal;
        if (legal) begin
          col_d   = '0;
          cnt_d   = '0;
          state_d = RD_FLT;
        end
      end
      RD_FLT: if (filter_valid) begin
        for (int l = 0; l < LANES; l++)
          if (8'(l) < q_n) flt_d[FAW'(cnt_q + 8'(l))] = filter[l*ELEM_W +: ELEM_W];
        cnt_d = cnt_q + q_n;
        if (cnt_q + q_n >= fl) begin
          cnt_d   = '0;
          state_d = RD_IFM;
        end
      end
      RD_IFM: if (ifmap_valid) begin
        for (int l = 0; l < LANES; l++)
          if (8'(l) < q_n) ifm_d[IAW'(cnt_q + 8'(l))] = ifmap[l*ELEM_W +: ELEM_W] ^ flip;
        cnt_d = cnt_q + q_n;
        if (cnt_q + q_n >= qrs) begin
          cnt_d   = '0;
          state_d = RD_IPS;
        end
      end
      RD_IPS: if (ipsum_valid) begin
        psum_d[PAW'(cnt_q)] = ipsum;
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == nps - 8'd1) begin
          cnt_d   = '0;
          j_d     = '0;
          k_d     = '0;
          l_d     = '0;
          state_d = CONV;
        end
      end
      // cnt walks the filter spad; j is the ifmap index, k/l the normal/depthwise psum slot.
      CONV: begin
        psum_d[PAW'(tgt)] = psum_q[PAW'(tgt)] + PSUM_W'(prod);
        cnt_d = cnt_q + 8'd1;
        if (j_q == qrs - 8'd1) begin
          j_d = '0;
          k_d = k_q + 8'd1;
        end else begin
          j_d = j_q + 8'd1;
        end
        l_d = (l_q == q_n - 8'd1) ? '0 : l_q + 8'd1;
        if (cnt_q == fl - 8'd1) begin
          cnt_d   = '0;
          state_d = WR_OPS;
        end
      end
      WR_OPS: if (opsum_ready) begin
        cnt_d = cnt_q + 8'd1;
        if (last_ops) begin
          if (col_q == cfg_q[6:2]) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            for (int i = 0; i < IFMAP_DEPTH; i++) begin
              if (i + int'(q_n) < IFMAP_DEPTH) ifm_d[i] = ifm_q[IAW'(i + int'(q_n))];
              else                             ifm_d[i] = '0;
            end
            col_d   = col_q + 5'd1;
            cnt_d   = qrs - q_n;
            state_d = RD_IFM;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cfg_q     <= '0;
      cfg_err_q <= 1'b0;
      col_q     <= '0;
      cnt_q     <= '0;
      j_q       <= '0;
      k_q       <= '0;
      l_q       <= '0;
      for (int i = 0; i < FILTER_DEPTH; i++) flt_q[i]  <= '0;
      for (int i = 0; i < IFMAP_DEPTH; i++)  ifm_q[i]  <= '0;
      for (int i = 0; i < PSUM_DEPTH; i++)   psum_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      cfg_q     <= cfg_d;
      cfg_err_q <= cfg_err_d;
      col_q     <= col_d;
      cnt_q     <= cnt_d;
      j_q       <= j_d;
      k_q       <= k_d;
      l_q       <= l_d;
      flt_q     <= flt_d;
      ifm_q     <= ifm_d;
      psum_q    <= psum_d;
    end
  end
endmodule

// File: tb/tb_pe_param.sv
// Directed bench for pe_param: a column-level arithmetic model predicts every opsum,
// literal values pin the model, and protocol checks run every cycle.
module tb_pe_param;
  logic        clk = 1'b0, rst_n = 1'b0, PE_en = 1'b0;
  logic [12:0] i_config = '0;
  logic [31:0] ifmap = '0, filter = '0, ipsum = '0;
  logic        ifmap_valid = 0, filter_valid = 0, ipsum_valid = 0, opsum_ready = 1;
  logic        ifmap_ready, filter_ready, ipsum_ready, opsum_valid;
  logic [31:0] opsum;
  logic        busy, done, cfg_err;

  always #5 clk = ~clk;

  pe_param dut (
    .clk(clk), .rst_n(rst_n), .PE_en(PE_en), .i_config(i_config),
    .ifmap(ifmap), .filter(filter), .ipsum(ipsum),
    .ifmap_valid(ifmap_valid), .filter_valid(filter_valid), .ipsum_valid(ipsum_valid),
    .opsum_ready(opsum_ready), .ifmap_ready(ifmap_ready), .filter_ready(filter_ready),
    .ipsum_ready(ipsum_ready), .opsum_valid(opsum_valid), .opsum(opsum),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  int total = 0, bad = 0;
  int expq[$], seen[$], wq[$], xq[$], pq[$];
  bit lastq[$];
  int nflt = 0, nifm = 0;
  logic hs;
  logic [31:0] v0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h @%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int sx(input int b, input int signed_mode);
    logic [7:0] y;
    y = b[7:0];
    if (signed_mode != 0) return int'($signed(y));
    return int'(y) - 128;
  endfunction

  // Expected opsums: per column, the window is the ifmap element stream starting at c*q.
  task automatic model(input int dw, rs, mode, p, F, q);
    int acc, qrs;
    qrs = q * rs;
    for (int c = 0; c <= F; c++) begin
      if (dw != 0) begin
        for (int ch = 0; ch < q; ch++) begin
          acc = pq[c*q + ch];
          for (int r = 0; r < rs; r++)
            acc += sx(wq[r*q + ch], 1) * sx(xq[c*q + r*q + ch], mode);
          expq.push_back(acc);
          lastq.push_back(c == F && ch == q - 1);
        end
      end else begin
        for (int k = 0; k < p; k++) begin
          acc = pq[c*p + k];
          for (int j = 0; j < qrs; j++)
            acc += sx(wq[k*qrs + j], 1) * sx(xq[c*q + j], mode);
          expq.push_back(acc);
          lastq.push_back(c == F && k == p - 1);
        end
      end
    end
  endtask

  function automatic logic [31:0] pack(input int base, input int q, input int src);
    logic [31:0] b;
    int v;
    b = 32'hA5A5_A5A5;
    for (int l = 0; l < q; l++) begin
      v = (src != 0) ? xq[base + l] : wq[base + l];
      b[l*8 +: 8] = v[7:0];
    end
    return b;
  endfunction

  function automatic logic rdy(input int ch);
    case (ch)
      0:       return filter_ready;
      1:       return ifmap_ready;
      default: return ipsum_ready;
    endcase
  endfunction

  task automatic xfer(input int ch, input logic [31:0] d);
    int n;
    n = 0;
    @(negedge clk);
    case (ch)
      0:       begin filter = d; filter_valid = 1; end
      1:       begin ifmap  = d; ifmap_valid  = 1; end
      default: begin ipsum  = d; ipsum_valid  = 1; end
    endcase
    while (!rdy(ch) && n < 300) begin @(negedge clk); n++; end
    if (n >= 300) begin
      total++; bad++;
      $display("FAIL xfer_timeout: channel %0d never ready", ch);
    end
    @(posedge clk); #1;
    filter_valid = 0; ifmap_valid = 0; ipsum_valid = 0;
  endtask

  task automatic start(input logic [12:0] cfg);
    @(negedge clk); i_config = cfg; PE_en = 1;
    @(negedge clk); PE_en = 0;
  endtask

  task automatic run_job(input int dw, rs, mode, p, F, q, input bit abort);
    int n, np, fl, nb, base;
    expq.delete(); lastq.delete(); seen.delete();
    model(dw, rs, mode, p, F, q);
    np = (dw != 0) ? q : p;
    fl = (dw != 0) ? q * rs : p * q * rs;
    start({dw[0], 2'(rs - 1), mode[0], 2'(p - 1), 5'(F), 2'(q - 1)});
    for (int b = 0; b < fl / q; b++) xfer(0, pack(b*q, q, 0));
    for (int c = 0; c <= F; c++) begin
      nb   = (c == 0) ? rs : 1;
      base = (c == 0) ? 0 : q*rs + (c - 1)*q;
      for (int b = 0; b < nb; b++) xfer(1, pack(base + b*q, q, 1));
      for (int k = 0; k < np; k++) xfer(2, pq[c*np + k]);
      if (abort) return;
    end
    n = 0;
    while (expq.size() != 0 && n < 1000) begin @(negedge clk); n++; end
    if (n >= 1000) begin
      total++; bad++;
      $display("FAIL drain_timeout: %0d opsums outstanding", expq.size());
    end
    @(negedge clk);
    chk("busy_after_done", busy, 0);
  endtask

  always @(negedge clk) begin
    hs = opsum_valid && opsum_ready;
    if (hs) begin
      if (expq.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_opsum: got %0h want none", opsum);
      end else begin
        chk("opsum", opsum, expq[0]);
        chk("done_on_hs", done, lastq[0]);
        seen.push_back(opsum);
        void'(expq.pop_front());
        void'(lastq.pop_front());
      end
    end else begin
      chk("done_no_hs", done, 0);
    end
    chk("mutex", ($countones({filter_ready, ifmap_ready, ipsum_ready, opsum_valid}) <= 1), 1);
  end

  always @(negedge clk) begin
    if (filter_valid && filter_ready) nflt++;
    if (ifmap_valid && ifmap_ready) nifm++;
  end

  task automatic chk_all_zero(input string nm);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_rdy"}, {filter_ready, ifmap_ready, ipsum_ready, opsum_valid}, 0);
    chk({nm, "_opsum"}, opsum, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_err"}, cfg_err, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench exceeded time limit");
    $fatal(1);
  end

  initial begin
    int n;
    #2 chk_all_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk_all_zero("post_reset");

    // Basic MAC
    wq = {1, 2, 3}; xq = {4, 5, 6}; pq = {10};
    run_job(0, 3, 1, 1, 0, 1, 0);
    chk("basic_lit", seen[0], 42);

    // Unsigned ifmap conversion
    wq = {1}; xq = {0}; pq = {0};
    run_job(0, 1, 0, 1, 0, 1, 0);
    chk("uns00_lit", seen[0], 32'hFFFF_FF80);
    xq = {129};
    run_job(0, 1, 0, 1, 0, 1, 0);
    chk("uns81_lit", seen[0], 1);

    // Sliding window
    nflt = 0; nifm = 0;
    wq = {1, 1, 1}; xq = {1, 2, 3, 4, 5}; pq = {0, 0, 0};
    run_job(0, 3, 1, 1, 2, 1, 0);
    chk("slide_n", seen.size(), 3);
    chk("slide0_lit", seen[0], 6);
    chk("slide1_lit", seen[1], 9);
    chk("slide2_lit", seen[2], 12);
    chk("slide_nflt", nflt, 3);
    chk("slide_nifm", nifm, 5);

    // Depthwise with opsum backpressure
    wq = {2, 3}; xq = {4, 5}; pq = {1, 1};
    opsum_ready = 0;
    fork
      run_job(1, 1, 1, 1, 0, 2, 0);
      begin
        n = 0;
        while (!opsum_valid && n < 300) begin @(negedge clk); n++; end
        chk("bp_seen_valid", opsum_valid, 1);
        v0 = opsum;
        repeat (5) begin
          @(negedge clk);
          chk("bp_valid", opsum_valid, 1);
          chk("bp_stable", opsum, v0);
        end
        opsum_ready = 1;
      end
    join
    chk("dw0_lit", seen[0], 9);
    chk("dw1_lit", seen[1], 16);

    // Full-width lanes, ifmap spad filled to depth, signed values, two columns
    wq.delete(); xq.delete();
    for (int i = 0; i < 24; i++) wq.push_back((i*7) % 11 - 5);
    for (int i = 0; i < 16; i++) xq.push_back((i*5) % 13 - 6);
    pq = {100, -7, 0, 5};
    run_job(0, 3, 1, 2, 1, 4, 0);
    chk("wide_n", seen.size(), 4);

    // Depthwise, unsigned, q=4 rs=3, three columns
    wq.delete(); xq.delete(); pq.delete();
    for (int i = 0; i < 12; i++) wq.push_back(i*19 - 100);
    for (int i = 0; i < 20; i++) xq.push_back((i*37) & 255);
    for (int i = 0; i < 12; i++) pq.push_back(i*1000 - 5000);
    run_job(1, 3, 0, 1, 2, 4, 0);
    chk("dwu_n", seen.size(), 12);

    // Reset asserted mid-CONV
    wq.delete(); xq = {1, 2, 3, 4}; pq = {0, 0, 0, 0};
    for (int i = 0; i < 16; i++) wq.push_back(i + 1);
    run_job(0, 4, 1, 4, 0, 1, 1);
    repeat (2) @(negedge clk);
    chk("conv_busy", busy, 1);
    chk("conv_rdy", {filter_ready, ifmap_ready, ipsum_ready, opsum_valid}, 0);
    rst_n = 0;
    #1 chk_all_zero("mid_reset");
    expq.delete(); lastq.delete();
    @(negedge clk); rst_n = 1;
    @(negedge clk);
    chk_all_zero("after_abort");

    // Illegal configs: filter overflow, then ifmap overflow in depthwise
    start({1'b0, 2'd3, 1'b1, 2'd3, 5'd0, 2'd3});
    chk("ill_err", cfg_err, 1);
    chk("ill_busy", busy, 0);
    chk("ill_rdy", {filter_ready, ifmap_ready, ipsum_ready, opsum_valid}, 0);
    @(negedge clk);
    chk("ill_sticky", cfg_err, 1);
    start({1'b1, 2'd3, 1'b1, 2'd0, 5'd0, 2'd3});
    chk("ill_dw_err", cfg_err, 1);
    chk("ill_dw_busy", busy, 0);

    // A legal start clears cfg_err
    wq = {1, 2, 3}; xq = {4, 5, 6}; pq = {10};
    run_job(0, 3, 1, 1, 0, 1, 0);
    chk("err_cleared", cfg_err, 0);
    chk("relegal_lit", seen[0], 42);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
